if_fetch_unit: RTL and testbench

Instruction-fetch stage of the pipelined MIPS core, directly upstream of the IF/ID pipeline register. Holds the PC and runs a single-outstanding request/ready handshake to instruction memory. Presents one buffered instruction plus its link PC (fetch address + 4) to IF/ID. Applies redirects from branch, jump, jr and exception logic, dropping any in-flight fetch that a redirect makes stale.

---
 rtl/if_fetch_unit.sv | 151 +++++++++++++++
 tb/tb_if_fetch_unit.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage. It holds the PC, keeps one request outstanding to instruction
// memory, and buffers one instruction with its link PC for IF/ID.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] ILLOP_PC = 32'h8000_0004,
  parameter logic [31:0] XADR_PC  = 32'h8000_0008
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [2:0]  pc_src,
  input  logic [31:0] branch_target,
  input  logic [31:0] jump_target,
  input  logic [31:0] jr_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] instruction,
  output logic [31:0] IF_PC,
  output logic        if_valid
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_PEND  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [2:0] SRC_BRANCH = 3'd1;
  localparam logic [2:0] SRC_JUMP   = 3'd2;
  localparam logic [2:0] SRC_JR     = 3'd3;
  localparam logic [2:0] SRC_ILLOP  = 3'd4;
  localparam logic [2:0] SRC_XADR   = 3'd5;

  logic [1:0]  state;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] redirect_pc;
  logic [31:0] buf_instr;
  logic [31:0] buf_pc;
  logic        buf_valid;

  logic        consume;
  logic        free;
  logic        redirect;
  logic        fill;
  logic [31:0] target;

  // Decode the redirect source. Codes 6 and 7 fall through as sequential.
  always_comb begin
    redirect = 1'b1;
    target   = pc;
    case (pc_src)
      SRC_BRANCH: target = branch_target;
      SRC_JUMP:   target = jump_target;
      SRC_JR:     target = jr_target & ~32'h3;
      SRC_ILLOP:  target = ILLOP_PC;
      SRC_XADR:   target = XADR_PC;
      default:    redirect = 1'b0;
    endcase
  end

  assign consume  = buf_valid & ~stall;
  assign free     = ~buf_valid | consume;
  assign pc_plus4 = pc + 32'd4;

  // A new request is issued only when the buffer can take the reply and no redirect is pending.
  always_comb begin
    imem_req = 1'b0;
    if (reset) begin
      case (state)
        ST_RUN:   imem_req = free & ~redirect;
        ST_PEND:  imem_req = 1'b1;
        ST_DRAIN: imem_req = 1'b1;
        default:  imem_req = 1'b0;
      endcase
    end
  end

  assign imem_addr = pc;
  assign fill      = imem_req & imem_ready & ~redirect & (state != ST_DRAIN);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ST_RUN;
      pc          <= RESET_PC;
      buf_pc      <= RESET_PC;
      buf_valid   <= 1'b0;
      redirect_pc <= RESET_PC;
    end else begin
      case (state)
        ST_RUN: begin
          if (redirect) begin
            buf_valid <= 1'b0;
            pc        <= target;
          end else if (fill) begin
            buf_valid <= 1'b1;
            buf_pc    <= pc_plus4;
            pc        <= pc_plus4;
          end else begin
            buf_valid <= buf_valid & ~consume;
            if (imem_req) begin
              state <= ST_PEND;
            end
          end
        end
        ST_PEND: begin
          if (imem_ready) begin
            state <= ST_RUN;
            if (redirect) begin
              buf_valid <= 1'b0;
              pc        <= target;
            end else begin
              buf_valid <= 1'b1;
              buf_pc    <= pc_plus4;
              pc        <= pc_plus4;
            end
          end else if (redirect) begin
            buf_valid   <= 1'b0;
            redirect_pc <= target;
            state       <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // The stale reply is swallowed, and the newest redirect target wins.
          buf_valid <= 1'b0;
          if (imem_ready) begin
            state <= ST_RUN;
            pc    <= redirect ? target : redirect_pc;
          end else if (redirect) begin
            redirect_pc <= target;
          end
        end
        default: begin
          state     <= ST_RUN;
          buf_valid <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (fill) begin
      buf_instr <= imem_rdata;
    end
  end

  assign instruction = buf_valid ? buf_instr : 32'h0;
  assign IF_PC       = buf_pc;
  assign if_valid    = buf_valid;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit. Memory with a variable latency returns each address as its data.
// A scoreboard pops every instruction that IF/ID consumes.
module tb_if_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic [2:0]  pc_src = 3'd0;
  logic [31:0] branch_target = 32'h0;
  logic [31:0] jump_target = 32'h0;
  logic [31:0] jr_target = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] instruction;
  logic [31:0] IF_PC;
  logic        if_valid;

  int lat = 0;
  int wait_cnt = 0;
  int vectors = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  if_fetch_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .pc_src(pc_src),
    .branch_target(branch_target), .jump_target(jump_target), .jr_target(jr_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_ready(imem_ready), .instruction(instruction), .IF_PC(IF_PC), .if_valid(if_valid)
  );

  assign imem_ready = imem_req && (wait_cnt >= lat);
  assign imem_rdata = imem_addr;

  always @(posedge clk) begin
    if (!reset || !imem_req || imem_ready) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] addr);
    exp_t e;
    e.instr = addr;
    e.pc    = addr + 32'd4;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset(input int new_lat);
    step();
    reset = 1'b0; stall = 1'b0; pc_src = 3'd0; lat = new_lat;
    settle();
    chk("rst_req_low", imem_req, 32'd0);
    step();
    settle();
    chk("rst_valid", if_valid, 32'd0);
    chk("rst_if_pc", IF_PC, RESET_PC);
    chk("rst_instr", instruction, 32'd0);
  endtask

  // An instruction counts as consumed on any live, unstalled cycle outside reset.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset && if_valid && !stall) begin
      if (exp_q.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL sb_unexpected: got instr %h IF_PC %h, required none", instruction, IF_PC);
      end else begin
        e = exp_q.pop_front();
        chk("sb_instr", instruction, e.instr);
        chk("sb_if_pc", IF_PC, e.pc);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    // Power-up reset state
    step(); step();
    chk("por_req", imem_req, 32'd0);
    chk("por_valid", if_valid, 32'd0);
    chk("por_if_pc", IF_PC, RESET_PC);
    chk("por_instr", instruction, 32'd0);

    // Zero-wait streaming; pc_src 6/7 act as sequential
    push(32'h8000_0000); push(32'h8000_0004); push(32'h8000_0008);
    step(); reset = 1'b1; settle();
    chk("s1_req", imem_req, 32'd1);
    chk("s1_addr", imem_addr, RESET_PC);
    step(); settle();
    chk("s1_first_valid", if_valid, 32'd1);
    step(); pc_src = 3'd6; branch_target = 32'h1234_5670; settle();
    chk("s1_src6_req", imem_req, 32'd1);
    step(); pc_src = 3'd7; settle();
    chk("s1_src7_addr", imem_addr, 32'h8000_000C);
    step(); pc_src = 3'd0; stall = 1'b1; settle();
    chk("s1_hold_req", imem_req, 32'd0);
    chk("s1_hold_if_pc", IF_PC, 32'h8000_0010);
    chk("s1_sb_empty", exp_q.size(), 32'd0);

    // Latency 2 with a four-cycle stall mid-stream
    do_reset(2);
    push(32'h8000_0000); push(32'h8000_0004); push(32'h8000_0008);
    step(); reset = 1'b1;
    step(); step();
    step(); settle();
    chk("s2_a_valid", if_valid, 32'd1);
    chk("s2_a_if_pc", IF_PC, 32'h8000_0004);
    step(); stall = 1'b1; settle();
    chk("s2_pend_valid", if_valid, 32'd0);
    chk("s2_pend_req", imem_req, 32'd1);
    step();
    for (int i = 0; i < 2; i++) begin
      step(); settle();
      chk("s2_stall_req", imem_req, 32'd0);
      chk("s2_stall_valid", if_valid, 32'd1);
      chk("s2_stall_if_pc", IF_PC, 32'h8000_0008);
      chk("s2_stall_instr", instruction, 32'h8000_0004);
    end
    step(); stall = 1'b0; settle();
    chk("s2_release_req", imem_req, 32'd1);
    chk("s2_release_addr", imem_addr, 32'h8000_0008);
    step(); step(); step(); settle();
    chk("s2_c_if_pc", IF_PC, 32'h8000_000C);
    step(); stall = 1'b1;
    chk("s2_sb_empty", exp_q.size(), 32'd0);

    // Jump while pending, overwritten during drain
    do_reset(4);
    push(32'h8000_0100);
    step(); reset = 1'b1;
    step(); pc_src = 3'd2; jump_target = 32'h8000_0500; settle();
    chk("s3_pend_req", imem_req, 32'd1);
    chk("s3_pend_addr", imem_addr, RESET_PC);
    step(); jump_target = 32'h8000_0100; settle();
    chk("s3_drain_req", imem_req, 32'd1);
    chk("s3_drain_addr", imem_addr, RESET_PC);
    chk("s3_drain_valid", if_valid, 32'd0);
    step(); pc_src = 3'd0; settle();
    chk("s3_drain_addr2", imem_addr, RESET_PC);
    step(); settle();
    chk("s3_ready_valid", if_valid, 32'd0);
    step(); settle();
    chk("s3_new_addr", imem_addr, 32'h8000_0100);
    chk("s3_new_valid", if_valid, 32'd0);
    repeat (5) step();
    settle();
    chk("s3_target_valid", if_valid, 32'd1);
    chk("s3_target_if_pc", IF_PC, 32'h8000_0104);
    step(); stall = 1'b1;
    chk("s3_sb_empty", exp_q.size(), 32'd0);

    // jr under stall, low address bits cleared
    do_reset(0);
    push(32'h0040_0004);
    step(); reset = 1'b1;
    step(); stall = 1'b1; pc_src = 3'd3; jr_target = 32'h0040_0007; settle();
    chk("s4_redir_req", imem_req, 32'd0);
    step(); pc_src = 3'd0; settle();
    chk("s4_valid", if_valid, 32'd0);
    chk("s4_addr", imem_addr, 32'h0040_0004);
    chk("s4_req", imem_req, 32'd1);
    step(); settle();
    chk("s4_held_if_pc", IF_PC, 32'h0040_0008);
    chk("s4_held_instr", instruction, 32'h0040_0004);
    chk("s4_held_req", imem_req, 32'd0);
    step(); stall = 1'b0;
    step(); stall = 1'b1;
    chk("s4_sb_empty", exp_q.size(), 32'd0);

    // Exception vectors arriving together with imem_ready
    do_reset(2);
    push(32'h8000_0004); push(32'h8000_0008);
    step(); reset = 1'b1;
    step(); step(); pc_src = 3'd4; settle();
    chk("s5_illop_ready", imem_ready, 32'd1);
    step(); pc_src = 3'd0; settle();
    chk("s5_illop_addr", imem_addr, 32'h8000_0004);
    chk("s5_illop_valid", if_valid, 32'd0);
    step(); step(); step(); settle();
    chk("s5_illop_if_pc", IF_PC, 32'h8000_0008);
    step(); step(); pc_src = 3'd5; settle();
    chk("s5_xadr_ready", imem_ready, 32'd1);
    step(); pc_src = 3'd0; settle();
    chk("s5_xadr_valid", if_valid, 32'd0);
    chk("s5_xadr_addr", imem_addr, 32'h8000_0008);
    step(); step(); step(); settle();
    chk("s5_xadr_if_pc", IF_PC, 32'h8000_000C);
    step(); stall = 1'b1;
    chk("s5_sb_empty", exp_q.size(), 32'd0);

    // Branch timing and PC wrap past 32'hFFFFFFFC
    do_reset(0);
    push(32'h8000_0000); push(32'h8000_0004); push(32'hFFFF_FFFC); push(32'h0000_0000);
    step(); reset = 1'b1;
    step();
    step(); pc_src = 3'd1; branch_target = 32'hFFFF_FFFC; settle();
    chk("s7_redir_req", imem_req, 32'd0);
    step(); pc_src = 3'd0; settle();
    chk("s7_t1_valid", if_valid, 32'd0);
    chk("s7_t1_addr", imem_addr, 32'hFFFF_FFFC);
    step(); settle();
    chk("s7_t2_if_pc", IF_PC, 32'h0000_0000);
    step(); settle();
    chk("s7_wrap_if_pc", IF_PC, 32'h0000_0004);
    step(); stall = 1'b1;
    chk("s7_sb_empty", exp_q.size(), 32'd0);

    // Reset asserted while a fetch is pending
    do_reset(3);
    push(32'h8000_0000);
    step(); reset = 1'b1;
    step(); settle();
    chk("s6_pend_req", imem_req, 32'd1);
    step(); reset = 1'b0; settle();
    chk("s6_rst_req", imem_req, 32'd0);
    step(); settle();
    chk("s6_after_req", imem_req, 32'd0);
    chk("s6_after_valid", if_valid, 32'd0);
    chk("s6_after_if_pc", IF_PC, RESET_PC);
    step(); reset = 1'b1; settle();
    chk("s6_restart_req", imem_req, 32'd1);
    chk("s6_restart_addr", imem_addr, RESET_PC);
    repeat (3) step();
    settle();
    chk("s6_wait_valid", if_valid, 32'd0);
    step(); settle();
    chk("s6_first_if_pc", IF_PC, 32'h8000_0004);
    step(); stall = 1'b1;
    chk("s6_sb_empty", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
